// File: rtl/prog_counter_if.sv
// Control and observation bundle for prog_counter.
// The master side drives the requests and din; the slave side is the counter.
interface prog_counter_if #(
    parameter int WIDTH = 8
);
    logic             Cp;
    logic             Lp;
    logic             Kp;
    logic             Rp;
    logic             Ep;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] pc_q;
    logic             wrap;
    logic             stk_empty;
    logic             stk_full;
    logic             stk_err;

    modport master (
        output Cp, Lp, Kp, Rp, Ep, din,
        input  bus, pc_q, wrap, stk_empty, stk_full, stk_err
    );

    modport slave (
        input  Cp, Lp, Kp, Rp, Ep, din,
        output bus, pc_q, wrap, stk_empty, stk_full, stk_err
    );
endinterface

// File: rtl/prog_counter.sv
// Program counter with increment, jump, call/return and gated bus output.
// Define PC_RET_STACK_EN to build in the return stack; without it Kp acts as Lp.
module prog_counter #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          clr,
    prog_counter_if.slave pc_if
);
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_inc;
    logic             wrap_reg;
    logic             wrap_next;

    assign pc_inc = pc_reg + WIDTH'(1);

`ifdef PC_RET_STACK_EN
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      occ_reg;
    logic [AW:0]      occ_next;
    logic             empty_reg;
    logic             full_reg;
    logic             err_reg;
    logic             err_next;
    logic             push;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] stack_mem [DEPTH];

    // When full the low bits wrap to zero, so top-1 still lands on DEPTH-1.
    assign top_idx = occ_reg[AW-1:0] - AW'(1);

    always_comb begin
        pc_next   = pc_reg;
        wrap_next = 1'b0;
        occ_next  = occ_reg;
        err_next  = err_reg;
        push      = 1'b0;
        if (pc_if.Rp) begin
            if (!empty_reg) begin
                pc_next  = stack_mem[top_idx];
                occ_next = occ_reg - (AW+1)'(1);
            end else begin
                err_next = 1'b1;
            end
        end else if (pc_if.Kp) begin
            pc_next = pc_if.din;
            if (!full_reg) begin
                push     = 1'b1;
                occ_next = occ_reg + (AW+1)'(1);
            end else begin
                err_next = 1'b1;
            end
        end else if (pc_if.Lp) begin
            pc_next = pc_if.din;
        end else if (pc_if.Cp) begin
            pc_next   = pc_inc;
            wrap_next = &pc_reg;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            occ_reg   <= '0;
            empty_reg <= 1'b1;
            full_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            occ_reg   <= occ_next;
            empty_reg <= (occ_next == '0);
            full_reg  <= (occ_next == (AW+1)'(DEPTH));
            err_reg   <= err_next;
        end
    end

    // Stack contents beyond occupancy are never read, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[occ_reg[AW-1:0]] <= pc_inc;
        end
    end

    assign pc_if.stk_empty = empty_reg;
    assign pc_if.stk_full  = full_reg;
    assign pc_if.stk_err   = err_reg;
`else
    logic unused_rp;

    assign unused_rp = pc_if.Rp;

    always_comb begin
        pc_next   = pc_reg;
        wrap_next = 1'b0;
        if (pc_if.Kp || pc_if.Lp) begin
            pc_next = pc_if.din;
        end else if (pc_if.Cp) begin
            pc_next   = pc_inc;
            wrap_next = &pc_reg;
        end
    end

    assign pc_if.stk_empty = 1'b1;
    assign pc_if.stk_full  = 1'b0;
    assign pc_if.stk_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_reg   <= RST_VAL;
            wrap_reg <= 1'b0;
        end else begin
            pc_reg   <= pc_next;
            wrap_reg <= wrap_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bus
            assign pc_if.bus[gi] = pc_if.Ep & pc_reg[gi];
        end
    endgenerate

    assign pc_if.pc_q = pc_reg;
    assign pc_if.wrap = wrap_reg;
endmodule

// File: tb/tb_prog_counter.sv
// Directed and random checks of prog_counter against a queue-based model.
module tb_prog_counter;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int RST_VAL = 0;
    localparam int MASK    = (1 << WIDTH) - 1;
`ifdef PC_RET_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic clk;
    logic clr;

    prog_counter_if #(.WIDTH(WIDTH)) pif ();

    prog_counter #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .RST_VAL(WIDTH'(RST_VAL))
    ) dut (
        .clk  (clk),
        .clr  (clr),
        .pc_if(pif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_pc;
    int m_stk[$];
    bit m_err;
    bit m_wrap;

    task automatic model_reset();
        m_pc   = RST_VAL;
        m_stk.delete();
        m_err  = 1'b0;
        m_wrap = 1'b0;
    endtask

    task automatic model_edge(bit r, bit k, bit l, bit c, int d);
        m_wrap = 1'b0;
        if (r && STK) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else                  m_err = 1'b1;
        end else if (k) begin
            if (STK) begin
                if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % (MASK + 1));
                else                      m_err = 1'b1;
            end
            m_pc = d & MASK;
        end else if (l) begin
            m_pc = d & MASK;
        end else if (c) begin
            m_wrap = (m_pc == MASK);
            m_pc   = (m_pc + 1) % (MASK + 1);
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".pc"},    32'(pif.pc_q), 32'(m_pc));
        check({tag, ".bus"},   32'(pif.bus), pif.Ep ? 32'(m_pc) : 32'd0);
        check({tag, ".wrap"},  32'(pif.wrap), 32'(m_wrap));
        check({tag, ".empty"}, 32'(pif.stk_empty), 32'(m_stk.size() == 0));
        check({tag, ".full"},  32'(pif.stk_full), 32'(m_stk.size() == DEPTH));
        check({tag, ".err"},   32'(pif.stk_err), 32'(m_err));
        $display("%0t %s Rp=%0b Kp=%0b Lp=%0b Cp=%0b din=%02h pc_q=%02h wrap=%0b e/f/err=%0b%0b%0b",
                 $time, tag, pif.Rp, pif.Kp, pif.Lp, pif.Cp, pif.din, pif.pc_q,
                 pif.wrap, pif.stk_empty, pif.stk_full, pif.stk_err);
    endtask

    task automatic step(string tag, bit r, bit k, bit l, bit c, int d);
        pif.Rp  = r;
        pif.Kp  = k;
        pif.Lp  = l;
        pif.Cp  = c;
        pif.din = WIDTH'(d);
        @(posedge clk);
        model_edge(r, k, l, c, d);
        #1;
        check_all(tag);
    endtask

    // Asynchronous clear between edges; checked before any edge arrives.
    task automatic async_clear(string tag);
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        clr     = 1'b1;
        pif.Rp  = 1'b0;
        pif.Kp  = 1'b0;
        pif.Lp  = 1'b0;
        pif.Cp  = 1'b0;
        pif.Ep  = 1'b1;
        pif.din = '0;
        model_reset();
        #12;
        check_all("reset");
        pif.Ep = 1'b0;
        #1;
        check_all("reset_ep0");
        pif.Ep = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        // Count with bus enabled, then gate the bus off
        for (int i = 0; i < 3; i++) step("count", 0, 0, 0, 1, 0);
        check("count_pc3", 32'(pif.pc_q), 32'h03);
        pif.Ep = 1'b0;
        #1;
        check_all("bus_off");
        check("bus_off_zero", 32'(pif.bus), 32'h00);
        pif.Ep = 1'b1;

        // Wrap around
        step("load_fe", 0, 0, 1, 0, 'hFE);
        step("inc_ff", 0, 0, 0, 1, 0);
        step("inc_00", 0, 0, 0, 1, 0);
        check("wrap_pulse", 32'(pif.wrap), 32'd1);
        step("after_wrap", 0, 0, 0, 1, 0);

        // Call, count, return
        step("load_10", 0, 0, 1, 0, 'h10);
        step("call_40", 0, 1, 0, 0, 'h40);
        step("inc_41", 0, 0, 0, 1, 0);
        step("ret", 1, 0, 0, 0, 0);

        // Fill, overflow, drain, underflow
        step("load_00", 0, 0, 1, 0, 'h00);
        for (int i = 1; i <= 5; i++) step("call_n", 0, 1, 0, 0, i * 'h10);
        for (int i = 0; i < 5; i++) step("ret_n", 1, 0, 0, 0, 0);

        // Everything at once with an empty stack
        async_clear("clr_a");
        step("all_req", 1, 1, 1, 1, 'h77);
        step("call_a", 0, 1, 0, 0, 'h20);
        step("call_b", 0, 1, 0, 0, 'h30);
        async_clear("clr_mid");
        step("post_clr", 1, 0, 0, 1, 0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            int sel;
            sel    = int'($urandom_range(0, 99));
            pif.Ep = 1'($urandom);
            if (sel < 3) begin
                async_clear("rnd_clr");
            end else begin
                step("rnd", sel < 20, (sel % 5) == 0, (sel % 7) == 0,
                     1'($urandom), int'($urandom_range(0, MASK)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
